// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared constants and helpers for the 4-digit BCD scan driver.
package bcd_disp_pkg;
    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam logic [15:0] ANODE_PAT = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [3:0] BCD_MAX = 4'd9;
    typedef logic [3:0] nibble_t;
    typedef logic [1:0] sel_t;
    function automatic logic has_bad_nibble(input logic [4*NUM_DIGITS-1:0] v);
        for (int i = 0; i < NUM_DIGITS; i++)
            if (v[4*i +: 4] > BCD_MAX) return 1'b1;
        return 1'b0;
    endfunction
endpackage

// File: rtl/bcd_scan_driver_prescaler.sv
// refresh_prescaler: free-running divider, tick high for one cycle every REFRESH_DIV clocks.
module refresh_prescaler #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    logic [W-1:0] r_cnt;
    assign tick = (r_cnt == W'(REFRESH_DIV - 1));
    always_ff @(posedge clk) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver: multiplexes a 4-digit BCD value onto a shared decoder bus and one-cold anodes.
module bcd_scan_driver
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit LZB = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic                    load_ready,
    input  logic                    display_en,
    output logic                    bcd_a,
    output logic                    bcd_b,
    output logic                    bcd_c,
    output logic                    bcd_d,
    output logic                    AN0,
    output logic                    AN1,
    output logic                    AN2,
    output logic                    AN3,
    output logic                    bcd_err
);
    logic                    w_tick;
    logic                    w_xfer;
    logic                    w_frame;
    logic                    w_lead;
    logic                    w_blank;
    nibble_t                 w_nib;
    sel_t                    r_sel;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic                    r_pflag;

    refresh_prescaler #(.REFRESH_DIV(REFRESH_DIV)) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (w_tick)
    );

    assign load_ready = !r_pflag;
    assign w_xfer     = load_valid && !r_pflag;
    assign w_frame    = w_tick && (r_sel == 2'd3);
    assign w_nib      = r_disp[{r_sel, 2'b00} +: 4];
    // Leading zero: this digit and every digit above it are zero; digit 0 always shows.
    assign w_lead     = (r_sel != 2'd0) && ((r_disp >> {r_sel, 2'b00}) == '0);
    assign w_blank    = !display_en || (w_nib > BCD_MAX) || (LZB && w_lead);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel   <= '0;
            r_disp  <= '0;
            r_pend  <= '0;
            r_pflag <= 1'b0;
            bcd_err <= 1'b0;
            {bcd_d, bcd_c, bcd_b, bcd_a} <= '0;
            {AN3, AN2, AN1, AN0}         <= ANODE_OFF;
        end else begin
            if (w_tick) r_sel <= r_sel + 1'b1;
            if (w_xfer) begin
                r_pend  <= load_value;
                r_pflag <= 1'b1;
                if (has_bad_nibble(load_value)) bcd_err <= 1'b1;
            end else if (w_frame && r_pflag) begin
                r_disp  <= r_pend;
                r_pflag <= 1'b0;
            end
            {bcd_d, bcd_c, bcd_b, bcd_a} <= w_nib;
            {AN3, AN2, AN1, AN0}         <= w_blank ? ANODE_OFF : ANODE_PAT[{r_sel, 2'b00} +: 4];
        end
    end
endmodule

// File: doc/bcd_scan_driver.md
Name: bcd_scan_driver

Overview:
Upstream neighbour of the BCD-to-7-segment decoder. It holds a 4-digit packed BCD value and time-multiplexes it across the four common-anode digits. Each refresh slot drives one nibble onto the decoder's a (LSB), b, c, d inputs and asserts the matching active-low anode. New values enter through a valid/ready handshake and are applied only at frame boundaries, so the display never tears.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (100 MHz -> 1 kHz slot rate); minimum 2.
LZB, 1, 1 = leading-zero blanking on; 0 = all four digits always shown.

Ports:
clk  input  1  system clock; the only clock.
rst_n  input  1  synchronous, active-low reset.
load_valid  input  1  source offers load_value this cycle.
load_value  input  16  packed BCD; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
load_ready  output  1  block can accept a value; equals !pend_flag.
display_en  input  1  0 = all anodes off; scanning continues.
bcd_a  output  1  current nibble bit 0, to decoder input a.
bcd_b  output  1  current nibble bit 1, to decoder input b.
bcd_c  output  1  current nibble bit 2, to decoder input c.
bcd_d  output  1  current nibble bit 3, to decoder input d.
AN0  output  1  digit 0 anode, active-low.
AN1  output  1  digit 1 anode, active-low.
AN2  output  1  digit 2 anode, active-low.
AN3  output  1  digit 3 anode, active-low.
bcd_err  output  1  sticky flag: a nibble greater than 9 was loaded.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets: prescaler cnt=0, sel=0, disp_reg=0, pending=0, pend_flag=0, bcd_err=0, AN0..AN3=1, bcd_a..d=0. load_ready is therefore 1 after reset. Any pending value is discarded.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick=1 for exactly the one cycle in which cnt==REFRESH_DIV-1.
- Digit select:
  - sel (2 bits) increments on tick and wraps 3->0.
  - A frame boundary is a tick while sel==3.
- Handshake:
  - A transfer occurs when load_valid && load_ready at a clk edge. On a transfer: pending<=load_value, pend_flag<=1.
  - The source must hold load_valid and load_value stable until the transfer.
  - At a frame boundary with pend_flag=1: disp_reg<=pending, pend_flag<=0. load_ready returns to 1 on the next cycle.
  - A transfer in the same cycle as a frame boundary is legal (pend_flag was 0). The value waits for the next boundary.
  - With REFRESH_DIV=4, worst-case load-to-display latency is 16 slot-cycles plus 1.
- Error flag: bcd_err<=1 on any transfer whose value contains a nibble >9. It clears only on reset.
- Outputs are registered, one cycle after sel or disp_reg changes:
  - {bcd_d,bcd_c,bcd_b,bcd_a} = disp_reg nibble[sel].
  - AN[sel]=0 and the other three anodes =1, unless the digit is blanked.
- Blanking: the slot's anode stays 1 while bcd still shows the nibble. A digit is blanked when any of these holds:
  - display_en=0;
  - its nibble >9;
  - LZB=1, sel>=1, and all nibbles from digit 3 down to digit sel are 0. Digit 0 is never blanked for LZB, so 0x0000 shows "0".
- Exactly one anode is low at a time; never more than one.

Decomposition:
- Package bcd_disp_pkg holds:
  - NUM_DIGITS=4;
  - ANODE_OFF=4'b1111;
  - the one-cold anode patterns per sel (4'b1110, 4'b1101, 4'b1011, 4'b0111);
  - BCD_MAX=9.
- One natural sub-module: refresh_prescaler (parameter REFRESH_DIV; ports clk, rst_n, tick).

Test Plan:
All scenarios use REFRESH_DIV=4.
1. Reset: hold rst_n=0 for 3 cycles -> AN0..3=1111, bcd=0, load_ready=1, bcd_err=0. Release -> first tick at cycle 4, sel advances 0->1.
2. Load and scan: LZB=0, display_en=1, load 0x1234 -> load_ready drops the next cycle. After the frame boundary, the repeating scan is {AN3..AN0, bcd} = 1110/4, 1101/3, 1011/2, 0111/1, each held 4 cycles. load_ready returns to 1.
3. Leading-zero blanking: LZB=1, load 0x0057 -> AN2 and AN3 never go low; digits 0 and 1 show 7 and 5. Load 0x0000 -> only AN0 goes low, with bcd=0.
4. Back-pressure: issue a second load_valid (0x9999) while pend_flag=1 -> load_ready=0 and no capture. It transfers the cycle after the boundary and is displayed one frame later.
5. Invalid BCD: load 0x00A3 -> bcd_err=1 and stays 1. Digit 1 slot has AN=1111. Digit 0 shows 3.
6. Reset mid-frame: assert rst_n=0 at sel=2 with a pending value -> the next edge gives all reset values. The pending value is never displayed.
